// File: rtl/ka4_mul_arbiter_if.sv
//============================================================================
// Module      : ka4_mul_arbiter_if
// Description : Request/response bundle between clients and ka4_mul_arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface ka4_mul_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_p;
    logic              rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

`default_nettype wire

// File: rtl/ka4_mul_arbiter.sv
//============================================================================
// Module      : ka4_mul_arbiter
// Description : Round-robin sharing of one 4x4 Karatsuba multiplier between
//               NREQ requesters; two-stage operand/result pipeline.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ka4_mul_arbiter #(
    parameter int NREQ = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ka4_mul_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    // 2-bit split: p = z2*16 + z1*4 + z0 with z1 = (ah+al)(bh+bl) - z2 - z0
    function automatic logic [7:0] ka4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] z2;
        logic [3:0] z0;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [5:0] zm;
        logic [5:0] z1;
        z2 = {2'b00, a[3:2]} * {2'b00, b[3:2]};
        z0 = {2'b00, a[1:0]} * {2'b00, b[1:0]};
        sa = {1'b0, a[3:2]} + {1'b0, a[1:0]};
        sb = {1'b0, b[3:2]} + {1'b0, b[1:0]};
        zm = {3'b000, sa} * {3'b000, sb};
        z1 = zm - {2'b00, z2} - {2'b00, z0};
        return {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
    endfunction

    logic            r_s1_valid;
    logic [3:0]      r_s1_a;
    logic [3:0]      r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_p;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  r_ptr;

    logic            w_adv2;
    logic            w_acc1;
    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic [IDW:0]    w_sum;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    logic [3:0]      w_sel_a;
    logic [3:0]      w_sel_b;
    logic [7:0]      w_prod;

    assign w_adv2 = !r_rsp_valid || bus.rsp_ready;
    assign w_acc1 = !r_s1_valid || w_adv2;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ))
                w_sum = w_sum - (IDW+1)'(NREQ);
            if (bus.req_valid[w_sum[IDW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (rst_n && w_any && w_acc1)
            w_ready[w_win] = 1'b1;
    end

    assign w_xfer        = |w_ready;
    assign bus.req_ready = w_ready;
    assign w_sel_a       = bus.req_a[{w_win, 2'b00} +: 4];
    assign w_sel_b       = bus.req_b[{w_win, 2'b00} +: 4];
    assign w_prod        = ka4_mul(r_s1_a, r_s1_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_adv2) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_p  <= w_prod;
                    r_rsp_id <= r_s1_id;
                end
            end
            if (w_acc1)
                r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_win;
                r_ptr   <= (w_win == c_last_id) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_ka4_mul_arbiter.sv
//============================================================================
// Module      : tb_ka4_mul_arbiter
// Description : Directed self-checking bench for ka4_mul_arbiter (NREQ=4 and 3).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ka4_mul_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ka4_mul_arbiter_if #(.NREQ(4)) bus ();
    ka4_mul_arbiter_if #(.NREQ(3)) bus3 ();

    ka4_mul_arbiter #(.NREQ(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    ka4_mul_arbiter #(.NREQ(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One clock; requesters accepted at this edge drop their valid afterwards.
    task automatic cycle4(output logic [3:0] g);
        g = bus.req_valid & bus.req_ready;
        tick();
        bus.req_valid = bus.req_valid & ~g;
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid  = '0;
        bus3.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        int ntx;
        int nrx;
        int exp_p  [4];
        int exp_id [4];

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;
        bus3.req_valid = '0;
        bus3.req_a     = '0;
        bus3.req_b     = '0;
        bus3.rsp_ready = 1'b1;
        @(negedge clk);
        #1;

        // Reset state, with requests pending so ready gating is visible
        bus.req_valid  = 4'hF;
        bus3.req_valid = 3'b111;
        #1;
        check("rst_ready",  int'(bus.req_ready), 0);
        check("rst_ready3", int'(bus3.req_ready), 0);
        check("rst_valid",  int'(bus.rsp_valid), 0);
        check("rst_p",      int'(bus.rsp_p), 0);
        check("rst_id",     int'(bus.rsp_id), 0);
        bus.req_valid  = '0;
        bus3.req_valid = '0;
        rst_n = 1'b1;
        #1;

        // Single request: 13*10 on requester 2
        bus.req_valid    = 4'b0100;
        bus.req_a[11:8]  = 4'd13;
        bus.req_b[11:8]  = 4'd10;
        #1;
        check("single_ready", int'(bus.req_ready), 4);
        cycle4(g);
        tick();
        check("single_valid", int'(bus.rsp_valid), 1);
        check("single_p",     int'(bus.rsp_p), 130);
        check("single_id",    int'(bus.rsp_id), 2);
        check("single_ptr",   int'(dut.r_ptr), 3);
        tick();
        check("single_drain", int'(bus.rsp_valid), 0);

        // All-request burst: a=i+1, b=15
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[4*i +: 4] = 4'(i + 1);
            bus.req_b[4*i +: 4] = 4'd15;
        end
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4)
                check("burst_ready", int'(bus.req_ready), 1 << k);
            if (k >= 2) begin
                check("burst_valid", int'(bus.rsp_valid), 1);
                check("burst_p",     int'(bus.rsp_p), 15 * (k - 1));
                check("burst_id",    int'(bus.rsp_id), k - 2);
            end
            cycle4(g);
        end

        // Backpressure: a=i+2, b=3, rsp_ready low for 5 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[4*i +: 4] = 4'(i + 2);
            bus.req_b[4*i +: 4] = 4'd3;
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        ntx = 0;
        for (int c = 0; c < 5; c++) begin
            check("bp_ready", int'(bus.req_ready), (c == 0) ? 1 : (c == 1) ? 2 : 0);
            if (c >= 2) begin
                check("bp_hold_valid", int'(bus.rsp_valid), 1);
                check("bp_hold_p",     int'(bus.rsp_p), 6);
                check("bp_hold_id",    int'(bus.rsp_id), 0);
            end
            cycle4(g);
            if (g != 4'b0000)
                ntx++;
        end
        check("bp_transfers", ntx, 2);
        exp_p  = '{6, 9, 12, 15};
        exp_id = '{0, 1, 2, 3};
        bus.rsp_ready = 1'b1;
        #1;
        nrx = 0;
        for (int it = 0; it < 6; it++) begin
            if (bus.rsp_valid) begin
                if (nrx < 4) begin
                    check("bp_rel_p",  int'(bus.rsp_p), exp_p[nrx]);
                    check("bp_rel_id", int'(bus.rsp_id), exp_id[nrx]);
                end
                nrx++;
            end
            cycle4(g);
        end
        check("bp_rel_count", nrx, 4);

        // Fairness between 0 and 3, plus 15*15 and 0*9 extremes
        do_reset();
        bus.req_a[3:0]   = 4'd15;
        bus.req_b[3:0]   = 4'd15;
        bus.req_a[15:12] = 4'd0;
        bus.req_b[15:12] = 4'd9;
        bus.req_valid    = 4'b1001;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("fair_ready", int'(bus.req_ready), (k % 2 == 0) ? 1 : 8);
            if (k >= 2) begin
                check("fair_p",  int'(bus.rsp_p), (k == 2) ? 225 : 0);
                check("fair_id", int'(bus.rsp_id), (k == 2) ? 0 : 3);
            end
            tick();
        end
        bus.req_valid = '0;
        tick();
        tick();

        // NREQ=3 pointer wrap from 2 to 0: a=i+1, b=2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus3.req_a[4*i +: 4] = 4'(i + 1);
            bus3.req_b[4*i +: 4] = 4'd2;
        end
        bus3.req_valid = 3'b111;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("n3_ready", int'(bus3.req_ready), 1 << (k % 3));
            if (k == 2) begin
                check("n3_p0",  int'(bus3.rsp_p), 2);
                check("n3_id0", int'(bus3.rsp_id), 0);
            end
            if (k == 4) begin
                check("n3_p2",  int'(bus3.rsp_p), 6);
                check("n3_id2", int'(bus3.rsp_id), 2);
            end
            tick();
        end
        bus3.req_valid = '0;

        // Reset while both stages are full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[4*i +: 4] = 4'd5;
            bus.req_b[4*i +: 4] = 4'd5;
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        tick();
        tick();
        check("mid_full_valid", int'(bus.rsp_valid), 1);
        check("mid_full_ready", int'(bus.req_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.rsp_valid), 0);
        check("mid_rst_p",     int'(bus.rsp_p), 0);
        check("mid_rst_id",    int'(bus.rsp_id), 0);
        check("mid_rst_ready", int'(bus.req_ready), 0);
        tick();
        bus.req_valid    = 4'b1100;
        bus.req_a[11:8]  = 4'd7;
        bus.req_b[11:8]  = 4'd3;
        bus.rsp_ready    = 1'b1;
        rst_n = 1'b1;
        #1;
        check("mid_first_grant", int'(bus.req_ready), 4);
        cycle4(g);
        bus.req_valid = '0;
        #1;
        check("mid_no_stale", int'(bus.rsp_valid), 0);
        tick();
        check("mid_new_valid", int'(bus.rsp_valid), 1);
        check("mid_new_p",     int'(bus.rsp_p), 21);
        check("mid_new_id",    int'(bus.rsp_id), 2);
        tick();
        check("mid_drain", int'(bus.rsp_valid), 0);

        // Exhaustive operand sweep through requester 1
        nrx = 0;
        for (int k = 0; k < 258; k++) begin
            if (k < 256) begin
                bus.req_valid   = 4'b0010;
                bus.req_a[7:4]  = k[7:4];
                bus.req_b[7:4]  = k[3:0];
            end else begin
                bus.req_valid = '0;
            end
            #1;
            if (bus.rsp_valid) begin
                check("exh_p",  int'(bus.rsp_p), (nrx / 16) * (nrx % 16));
                check("exh_id", int'(bus.rsp_id), 1);
                nrx++;
            end
            tick();
        end
        check("exh_count", nrx, 256);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
